dmac_ctrl_arbiter: RTL and testbench
====================================

DMAC_CTRL_ARBITER -- requirements
Module: dmac_ctrl_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 10: number of control requesters (cores, cluster ctrl, FC ctrl).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: control data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: control address width.
REQ-004 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8: byte-enable width.
REQ-005 SHALL have parameter ID_WIDTH, default $clog2(NB_REQ): requester id width.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255: response timeout limit.
REQ-007 SHALL have parameter ERR_DATA, default 32'hBADCAB1E: read data returned on timeout.
REQ-008 SHALL use one clock and a synchronous active-high reset; no other clock or reset input exists.
REQ-009 SHALL have port clk_i, input, 1: clock, rising edge.
REQ-010 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-011 SHALL have ports s_req_i, input, NB_REQ, and s_wen_i, input, NB_REQ (1 = read): requester requests.
REQ-012 SHALL have ports s_add_i, input, NB_REQ x ADDR_WIDTH; s_be_i, input, NB_REQ x BE_WIDTH; s_wdata_i, input, NB_REQ x DATA_WIDTH: requester payloads.
REQ-013 SHALL have ports s_gnt_o, output, NB_REQ; s_r_valid_o, output, NB_REQ; s_r_rdata_o, output, DATA_WIDTH (shared by all requesters).
REQ-014 SHALL have ports m_req_o, output, 1; m_add_o, output, ADDR_WIDTH; m_type_o, output, 1; m_be_o, output, BE_WIDTH; m_wdata_o, output, DATA_WIDTH; m_id_o, output, ID_WIDTH: DMA control target request.
REQ-015 SHALL have ports m_gnt_i, input, 1; m_r_valid_i, input, 1; m_r_rdata_i, input, DATA_WIDTH; m_r_id_i, input, ID_WIDTH: DMA control target response.
REQ-016 SHALL have ports busy_o, output, 1 (FSM not IDLE) and err_o, output, 1 (one-cycle error pulse).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE and RESP; exactly one transaction is outstanding at a time.
REQ-018 IDLE, any s_req_i set: SHALL select the winner as the lowest index >= rr_ptr with req set, wrapping modulo NB_REQ; capture its add, wen, be, wdata and index into registers; go to ISSUE next cycle.
REQ-019 IDLE, no request: SHALL stay in IDLE, with m_req_o=0 and all s_gnt_o=0.
REQ-020 ISSUE: SHALL drive m_req_o=1 and m_* from the captured registers (m_type_o=wen, m_id_o=captured index), holding them stable until m_gnt_i.
REQ-021 ISSUE with m_gnt_i=1: SHALL assert s_gnt_o[winner]=1 combinationally in the same cycle for exactly one cycle, set rr_ptr to (winner+1) mod NB_REQ, and go to RESP.
REQ-022 s_gnt_o SHALL be asserted only as specified in REQ-021; minimum request-to-grant latency is 1 cycle.
REQ-023 Requesters SHALL hold s_req_i and payload until granted; a dropped request after capture is still issued.
REQ-024 RESP with m_r_valid_i=1: SHALL assert s_r_valid_o[id_q]=1 for one cycle and set s_r_rdata_o=m_r_rdata_i (combinational), then go to IDLE.
REQ-025 RESP response with m_r_id_i != id_q: SHALL still route it to id_q and pulse err_o.
REQ-026 RESP timeout: an 8-bit-or-wider counter SHALL clear on entry to RESP and increment each RESP cycle without m_r_valid_i.
REQ-027 RESP timeout: when the counter reaches TIMEOUT_CYCLES, SHALL assert s_r_valid_o[id_q] with s_r_rdata_o=ERR_DATA, pulse err_o, and go to IDLE.
REQ-028 m_r_valid_i in IDLE or ISSUE: SHALL be dropped and err_o pulsed; FSM state is unchanged.
REQ-029 A request arriving in the same cycle RESP completes: SHALL be arbitrated in the following IDLE cycle, so back-to-back throughput is 1 transaction per 3 cycles minimum.
REQ-030 s_r_rdata_o SHALL be 0 when no s_r_valid_o bit is set.
REQ-031 busy_o SHALL be 1 in ISSUE and RESP.

Reset
REQ-032 On rst_i=1 at a clock edge: state=IDLE, rr_ptr=0, counter=0, captured registers=0.
REQ-033 During and after reset, all outputs SHALL be 0 (m_req_o, s_gnt_o, s_r_valid_o, err_o, busy_o, and m_* data).
REQ-034 Reset mid-transaction SHALL abandon the transaction with no grant or response to the requester; a late m_r_valid_i is handled per REQ-028.

Verification
REQ-035 Single request: s_req_i[3]=1, read, add=0x10; m_gnt_i tied to 1; m_r_valid_i one cycle after grant with rdata=0xCAFE -> s_gnt_o[3] at cycle 1, s_r_valid_o[3] with 0xCAFE at cycle 2, rr_ptr=4.
REQ-036 Round-robin: all 10 requesters held high -> grants in order 0,1,...,9,0, one per transaction, no starvation.
REQ-037 Backpressure: m_gnt_i low for 5 cycles -> m_req_o and m_add_o stable for all 5 cycles, exactly one s_gnt_o pulse.
REQ-038 Timeout: no m_r_valid_i after grant to requester 2 -> 255 cycles later s_r_valid_o[2]=1, s_r_rdata_o=0xBADCAB1E, err_o pulse, FSM back to IDLE.
REQ-039 Errors: m_r_id_i=5 while id_q=2 -> response delivered to requester 2 and err_o=1; spurious m_r_valid_i in IDLE -> err_o=1, no s_r_valid_o.
REQ-040 Reset in RESP -> next cycle all outputs 0; a new request afterward is arbitrated with rr_ptr=0.

Source files
------------

// File: rtl/dmac_ctrl_arbiter.sv
// Control-port arbiter: round-robin selection among NB_REQ requesters onto a
// single DMA control target, one outstanding transaction at a time, with a
// response timeout that answers the requester with ERR_DATA.
module dmac_ctrl_arbiter #(
    parameter int unsigned           NB_REQ         = 10,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned           ID_WIDTH       = $clog2(NB_REQ),
    parameter int unsigned           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hBADCAB1E
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NB_REQ-1:0]                 s_req_i,
    input  logic [NB_REQ-1:0]                 s_wen_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0] s_add_i,
    input  logic [NB_REQ-1:0][BE_WIDTH-1:0]   s_be_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0] s_wdata_i,
    output logic [NB_REQ-1:0]                 s_gnt_o,
    output logic [NB_REQ-1:0]                 s_r_valid_o,
    output logic [DATA_WIDTH-1:0]             s_r_rdata_o,
    output logic                              m_req_o,
    output logic [ADDR_WIDTH-1:0]             m_add_o,
    output logic                              m_type_o,
    output logic [BE_WIDTH-1:0]               m_be_o,
    output logic [DATA_WIDTH-1:0]             m_wdata_o,
    output logic [ID_WIDTH-1:0]               m_id_o,
    input  logic                              m_gnt_i,
    input  logic                              m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]             m_r_rdata_i,
    input  logic [ID_WIDTH-1:0]               m_r_id_i,
    output logic                              busy_o,
    output logic                              err_o
);

    // Counter is at least 8 bits and always wide enough for the limit.
    localparam int unsigned CNT_WIDTH =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // The timeout fires in the RESP cycle whose count, once incremented,
    // reaches TIMEOUT_CYCLES: i.e. TIMEOUT_CYCLES cycles after the grant.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   add_q, add_d;
    logic                    wen_q, wen_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic                    win_found;
    logic [ID_WIDTH-1:0]     win_idx;
    logic [ID_WIDTH-1:0]     cand;

    logic [NB_REQ-1:0]       gnt_c, rvalid_c;
    logic [DATA_WIDTH-1:0]   rdata_c;
    logic                    err_c;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path leaves a signal unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            cand = ID_WIDTH'((32'(rr_ptr_q) + i) % NB_REQ);
            if (!win_found && s_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state, capture and response-routing logic.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        add_d    = add_q;
        wen_d    = wen_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        gnt_c    = '0;
        rvalid_c = '0;
        rdata_c  = '0;
        err_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A response with nothing outstanding is dropped and flagged.
                err_c = m_r_valid_i;
                if (win_found) begin
                    id_d    = win_idx;
                    add_d   = s_add_i[win_idx];
                    wen_d   = s_wen_i[win_idx];
                    be_d    = s_be_i[win_idx];
                    wdata_d = s_wdata_i[win_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                err_c = m_r_valid_i;
                if (m_gnt_i) begin
                    gnt_c[id_q] = 1'b1;
                    rr_ptr_d    = (id_q == ID_WIDTH'(NB_REQ - 1)) ? '0 : id_q + 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_r_valid_i) begin
                    // Always routed to the captured requester; a foreign id
                    // only raises the error flag.
                    rvalid_c[id_q] = 1'b1;
                    rdata_c        = m_r_rdata_i;
                    err_c          = (m_r_id_i != id_q);
                    state_d        = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rvalid_c[id_q] = 1'b1;
                    rdata_c        = ERR_DATA;
                    err_c          = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured-transaction registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            add_q    <= '0;
            wen_q    <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            add_q    <= add_d;
            wen_q    <= wen_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted, so a reset arriving
    // mid-transaction never leaks a grant or response.
    logic issuing;
    assign issuing     = (state_q == ST_ISSUE) && !rst_i;

    assign s_gnt_o     = rst_i ? '0 : gnt_c;
    assign s_r_valid_o = rst_i ? '0 : rvalid_c;
    assign s_r_rdata_o = rst_i ? '0 : rdata_c;
    assign err_o       = rst_i ? 1'b0 : err_c;
    assign busy_o      = !rst_i && (state_q != ST_IDLE);

    assign m_req_o     = issuing;
    assign m_add_o     = issuing ? add_q : '0;
    assign m_type_o    = issuing & wen_q;
    assign m_be_o      = issuing ? be_q : '0;
    assign m_wdata_o   = issuing ? wdata_q : '0;
    assign m_id_o      = issuing ? id_q : '0;

endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Self-checking bench for dmac_ctrl_arbiter: a transaction-level model
// predicts every output each cycle; directed scenarios pin the model with
// literal expectations, then a randomized phase exercises the rest.
module tb_dmac_ctrl_arbiter;

    localparam int NB = 10;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 4;
    localparam int IW = 4;
    localparam int TO = 255;
    localparam logic [DW-1:0] ERR = 32'hBADCAB1E;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                      rst_i;
    logic [NB-1:0]             s_req_i, s_wen_i;
    logic [NB-1:0][AW-1:0]     s_add_i;
    logic [NB-1:0][BW-1:0]     s_be_i;
    logic [NB-1:0][DW-1:0]     s_wdata_i;
    logic [NB-1:0]             s_gnt_o, s_r_valid_o;
    logic [DW-1:0]             s_r_rdata_o;
    logic                      m_req_o, m_type_o;
    logic [AW-1:0]             m_add_o;
    logic [BW-1:0]             m_be_o;
    logic [DW-1:0]             m_wdata_o;
    logic [IW-1:0]             m_id_o;
    logic                      m_gnt_i, m_r_valid_i;
    logic [DW-1:0]             m_r_rdata_i;
    logic [IW-1:0]             m_r_id_i;
    logic                      busy_o, err_o;

    dmac_ctrl_arbiter #(
        .NB_REQ(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW),
        .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_wen_i(s_wen_i), .s_add_i(s_add_i),
        .s_be_i(s_be_i), .s_wdata_i(s_wdata_i),
        .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_type_o(m_type_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_id_o(m_id_o),
        .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i),
        .m_r_rdata_i(m_r_rdata_i), .m_r_id_i(m_r_id_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Transaction-level model: is a transaction held, has the target taken it,
    // how many silent response cycles have passed, where the rotation starts.
    bit            mdl_busy, mdl_granted, prev_rst;
    int            mdl_ptr, mdl_wait;
    int            tx_id;
    logic [AW-1:0] tx_add;
    logic          tx_wen;
    logic [BW-1:0] tx_be;
    logic [DW-1:0] tx_wdata;

    int n_tests, n_fail, cyc;

    // Observations of the DUT, used only by the literal checks.
    logic [NB-1:0] obs_gnt, obs_rv, rv_vec;
    logic [DW-1:0] obs_rdata, rv_rdata;
    logic [AW-1:0] obs_madd;
    logic          obs_err, obs_mreq, obs_busy, rv_err;
    int            gnt_log[$];
    int            last_gnt_cyc, last_rv_cyc;

    // Random requester population.
    bit            pend[NB], dropped[NB];
    logic          r_wen[NB];
    logic [AW-1:0] r_add[NB];
    logic [BW-1:0] r_be[NB];
    logic [DW-1:0] r_wdata[NB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict this cycle's outputs, compare, then advance the model.
    task automatic compare_cycle();
        logic [NB-1:0] e_gnt, e_rv;
        logic [DW-1:0] e_rdata;
        logic          e_mreq, e_err, e_busy;
        bit            chk_payload;
        e_gnt = '0; e_rv = '0; e_rdata = '0;
        e_mreq = 1'b0; e_err = 1'b0; e_busy = 1'b0;
        chk_payload = rst_i || prev_rst;
        if (!rst_i) begin
            if (!mdl_busy) begin
                e_err = m_r_valid_i;
            end else if (!mdl_granted) begin
                e_busy = 1'b1; e_mreq = 1'b1; e_err = m_r_valid_i; chk_payload = 1'b1;
                if (m_gnt_i) e_gnt[tx_id] = 1'b1;
            end else begin
                e_busy = 1'b1;
                if (m_r_valid_i) begin
                    e_rv[tx_id] = 1'b1; e_rdata = m_r_rdata_i;
                    e_err = (int'(m_r_id_i) != tx_id);
                end else if (mdl_wait + 1 == TO) begin
                    e_rv[tx_id] = 1'b1; e_rdata = ERR; e_err = 1'b1;
                end
            end
        end
        check("s_gnt_o", s_gnt_o, e_gnt);
        check("s_r_valid_o", s_r_valid_o, e_rv);
        check("s_r_rdata_o", s_r_rdata_o, e_rdata);
        check("m_req_o", m_req_o, e_mreq);
        check("err_o", err_o, e_err);
        check("busy_o", busy_o, e_busy);
        if (chk_payload) begin
            check("m_add_o", m_add_o, e_mreq ? tx_add : '0);
            check("m_type_o", m_type_o, e_mreq ? tx_wen : 1'b0);
            check("m_be_o", m_be_o, e_mreq ? tx_be : '0);
            check("m_wdata_o", m_wdata_o, e_mreq ? tx_wdata : '0);
            check("m_id_o", m_id_o, e_mreq ? IW'(tx_id) : '0);
        end

        obs_gnt = s_gnt_o; obs_rv = s_r_valid_o; obs_rdata = s_r_rdata_o;
        obs_err = err_o; obs_mreq = m_req_o; obs_busy = busy_o; obs_madd = m_add_o;
        if (s_gnt_o != '0) begin
            for (int j = 0; j < NB; j++) if (s_gnt_o[j]) gnt_log.push_back(j);
            last_gnt_cyc = cyc;
        end
        if (s_r_valid_o != '0) begin
            last_rv_cyc = cyc; rv_vec = s_r_valid_o; rv_rdata = s_r_rdata_o; rv_err = err_o;
        end

        prev_rst = rst_i;
        if (rst_i) begin
            mdl_busy = 0; mdl_granted = 0; mdl_ptr = 0; mdl_wait = 0;
            tx_id = 0; tx_add = '0; tx_wen = 1'b0; tx_be = '0; tx_wdata = '0;
        end else if (!mdl_busy) begin
            for (int k = 0; k < NB; k++) begin
                int j;
                j = (mdl_ptr + k) % NB;
                if (!mdl_busy && s_req_i[j]) begin
                    mdl_busy = 1; mdl_granted = 0; tx_id = j;
                    tx_add = s_add_i[j]; tx_wen = s_wen_i[j];
                    tx_be = s_be_i[j]; tx_wdata = s_wdata_i[j];
                end
            end
        end else if (!mdl_granted) begin
            if (m_gnt_i) begin
                mdl_granted = 1; mdl_ptr = (tx_id + 1) % NB; mdl_wait = 0;
                pend[tx_id] = 0; dropped[tx_id] = 0;
            end
        end else begin
            if (e_rv != '0) begin
                mdl_busy = 0; mdl_granted = 0;
            end else begin
                mdl_wait++;
            end
        end
        cyc++;
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
        compare_cycle();
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; s_req_i = '0; s_wen_i = '0; s_add_i = '0; s_be_i = '0;
        s_wdata_i = '0; m_gnt_i = 1'b0; m_r_valid_i = 1'b0; m_r_rdata_i = '0; m_r_id_i = '0;
    endtask

    task automatic rand_stage();
        idle_inputs();
        for (int i = 0; i < NB; i++) begin
            if (!pend[i] && $urandom_range(3) == 0) begin
                pend[i] = 1; dropped[i] = 0;
                r_wen[i] = 1'($urandom_range(1)); r_add[i] = $urandom;
                r_be[i] = BW'($urandom); r_wdata[i] = $urandom;
            end
            // A captured requester may let go; the transaction must still run.
            if (pend[i] && mdl_busy && !mdl_granted && tx_id == i && $urandom_range(3) == 0)
                dropped[i] = 1;
            s_req_i[i] = pend[i] && !dropped[i];
            s_wen_i[i] = r_wen[i]; s_add_i[i] = r_add[i];
            s_be_i[i] = r_be[i]; s_wdata_i[i] = r_wdata[i];
        end
        m_gnt_i = ($urandom_range(9) < 7);
        if (mdl_busy && mdl_granted) m_r_valid_i = 1'($urandom_range(1));
        else m_r_valid_i = ($urandom_range(19) == 0);
        m_r_rdata_i = $urandom;
        m_r_id_i = ($urandom_range(9) == 0) ? IW'($urandom_range(NB - 1)) : IW'(tx_id);
        rst_i = ($urandom_range(199) == 0);
        if (rst_i) for (int i = 0; i < NB; i++) begin pend[i] = 0; dropped[i] = 0; end
    endtask

    int gnt_cyc, pulses;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; prev_rst = 0;
        mdl_busy = 0; mdl_granted = 0; mdl_ptr = 0; mdl_wait = 0; tx_id = 0;
        tx_add = '0; tx_wen = 1'b0; tx_be = '0; tx_wdata = '0;
        last_gnt_cyc = -1; last_rv_cyc = -1;
        for (int i = 0; i < NB; i++) begin
            pend[i] = 0; dropped[i] = 0; r_wen[i] = 1'b0; r_add[i] = '0; r_be[i] = '0; r_wdata[i] = '0;
        end
        idle_inputs();
        rst_i = 1'b1;

        // Reset with busy-looking inputs: everything must stay low.
        for (int k = 0; k < 3; k++) begin
            next(); idle_inputs(); rst_i = 1'b1; s_req_i = '1; m_gnt_i = 1'b1; m_r_valid_i = 1'b1;
            sample();
        end
        check("reset busy", obs_busy, 1'b0);
        check("reset gnt", obs_gnt, '0);

        // Single read from requester 3.
        next(); idle_inputs(); s_req_i[3] = 1'b1; s_wen_i[3] = 1'b1; s_add_i[3] = 32'h10; m_gnt_i = 1'b1;
        sample();
        next(); idle_inputs(); s_req_i[3] = 1'b1; s_wen_i[3] = 1'b1; s_add_i[3] = 32'h10; m_gnt_i = 1'b1;
        sample();
        check("single gnt", obs_gnt, 10'h008);
        check("single m_add", obs_madd, 32'h10);
        next(); idle_inputs(); m_r_valid_i = 1'b1; m_r_rdata_i = 32'hCAFE; m_r_id_i = 4'd3;
        sample();
        check("single rvalid", obs_rv, 10'h008);
        check("single rdata", obs_rdata, 32'hCAFE);
        check("single err", obs_err, 1'b0);
        // rr_ptr is now 4: requester 5 must beat requester 3.
        next(); idle_inputs(); s_req_i[3] = 1'b1; s_req_i[5] = 1'b1; m_gnt_i = 1'b1; sample();
        next(); idle_inputs(); s_req_i[3] = 1'b1; s_req_i[5] = 1'b1; m_gnt_i = 1'b1; sample();
        check("ptr4 first gnt", obs_gnt, 10'h020);
        next(); idle_inputs(); s_req_i[3] = 1'b1; m_r_valid_i = 1'b1; m_r_id_i = 4'd5; sample();
        next(); idle_inputs(); s_req_i[3] = 1'b1; m_gnt_i = 1'b1; sample();
        next(); idle_inputs(); s_req_i[3] = 1'b1; m_gnt_i = 1'b1; sample();
        check("ptr4 second gnt", obs_gnt, 10'h008);
        next(); idle_inputs(); m_r_valid_i = 1'b1; m_r_id_i = 4'd3; sample();

        // Round robin with every requester held high from rr_ptr=0.
        next(); idle_inputs(); rst_i = 1'b1; sample();
        gnt_log.delete();
        for (int k = 0; k < 33; k++) begin
            next(); idle_inputs(); s_req_i = '1; m_gnt_i = 1'b1;
            m_r_valid_i = mdl_busy && mdl_granted; m_r_id_i = IW'(tx_id); m_r_rdata_i = 32'(k);
            sample();
        end
        check("rr grant count", gnt_log.size(), 11);
        for (int k = 0; k < 11 && k < gnt_log.size(); k++) check("rr order", gnt_log[k], k % 10);

        // Backpressure: five cycles without m_gnt_i.
        pulses = 0;
        next(); idle_inputs(); s_req_i[7] = 1'b1; s_add_i[7] = 32'h1234_5678; s_be_i[7] = 4'hA;
        s_wdata_i[7] = 32'hDEAD_BEEF; sample();
        for (int k = 0; k < 6; k++) begin
            next(); idle_inputs(); s_req_i[7] = 1'b1; s_add_i[7] = 32'h1234_5678; s_be_i[7] = 4'hA;
            s_wdata_i[7] = 32'hDEAD_BEEF; m_gnt_i = (k == 5); sample();
            check("bp m_req", obs_mreq, 1'b1);
            check("bp m_add", obs_madd, 32'h1234_5678);
            if (obs_gnt != '0) pulses++;
        end
        next(); idle_inputs(); m_r_valid_i = 1'b1; m_r_id_i = 4'd7; sample();
        if (obs_gnt != '0) pulses++;
        check("bp gnt pulses", pulses, 1);

        // Timeout on requester 2.
        next(); idle_inputs(); s_req_i[2] = 1'b1; m_gnt_i = 1'b1; sample();
        next(); idle_inputs(); s_req_i[2] = 1'b1; m_gnt_i = 1'b1; sample();
        gnt_cyc = last_gnt_cyc; last_rv_cyc = -1;
        for (int k = 0; k < 300; k++) begin next(); idle_inputs(); sample(); end
        check("timeout latency", last_rv_cyc - gnt_cyc, TO);
        check("timeout rvalid", rv_vec, 10'h004);
        check("timeout rdata", rv_rdata, ERR);
        check("timeout err", rv_err, 1'b1);
        check("timeout idle", obs_busy, 1'b0);

        // Wrong response id, then a spurious response in IDLE.
        next(); idle_inputs(); s_req_i[2] = 1'b1; m_gnt_i = 1'b1; sample();
        next(); idle_inputs(); s_req_i[2] = 1'b1; m_gnt_i = 1'b1; sample();
        next(); idle_inputs(); m_r_valid_i = 1'b1; m_r_id_i = 4'd5; m_r_rdata_i = 32'h1111; sample();
        check("bad id rvalid", obs_rv, 10'h004);
        check("bad id err", obs_err, 1'b1);
        check("bad id rdata", obs_rdata, 32'h1111);
        next(); idle_inputs(); m_r_valid_i = 1'b1; sample();
        check("spurious err", obs_err, 1'b1);
        check("spurious rvalid", obs_rv, '0);

        // Reset while waiting for a response.
        next(); idle_inputs(); s_req_i[6] = 1'b1; m_gnt_i = 1'b1; sample();
        next(); idle_inputs(); s_req_i[6] = 1'b1; m_gnt_i = 1'b1; sample();
        next(); idle_inputs(); rst_i = 1'b1; sample();
        next(); idle_inputs(); sample();
        check("post-reset busy", obs_busy, 1'b0);
        check("post-reset rvalid", obs_rv, '0);
        check("post-reset err", obs_err, 1'b0);
        next(); idle_inputs(); s_req_i[1] = 1'b1; s_req_i[8] = 1'b1; m_r_valid_i = 1'b1; sample();
        check("late response err", obs_err, 1'b1);
        next(); idle_inputs(); s_req_i[1] = 1'b1; s_req_i[8] = 1'b1; m_gnt_i = 1'b1; sample();
        check("post-reset ptr0 gnt", obs_gnt, 10'h002);
        next(); idle_inputs(); s_req_i[8] = 1'b1; m_r_valid_i = 1'b1; m_r_id_i = 4'd1; sample();

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            next(); rand_stage(); sample();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
